pixel_frame_loader: RTL and testbench
=====================================

Name: pixel_frame_loader

Overview:
- Upstream feeder for the MLP inference core.
- Accepts a raster-order stream of 8-bit unsigned grayscale pixels over a valid/ready handshake and quantizes each pixel to signed 8-bit, non-negative.
- Stores one 28x28 frame in a 784-entry register buffer.
- Presents the frame as a stable parallel array with frame_valid until the MLP side acknowledges it with frame_ack.

Parameters:
- PIXELS_NUMBER, 784, pixels per frame; the counter width derives from it.
- RESOLUTION, 8, pixel width in bits, both input and output.
- INVERT, 0, when 1 the pixel is complemented (255-p) before quantization, for white-background sources.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  RESOLUTION  unsigned grayscale pixel.
- pix_valid  in  1  pix_in/pix_sof valid this cycle.
- pix_sof  in  1  marks the first pixel of a frame; qualified by pix_valid.
- pix_ready  out  1  loader can accept a pixel this cycle.
- pixels  out  signed RESOLUTION x PIXELS_NUMBER (unpacked [PIXELS_NUMBER-1:0])  buffered quantized frame.
- frame_valid  out  1  pixels holds a complete frame.
- frame_ack  in  1  consumer has latched/used the frame.
- resync_err  out  1  one-cycle pulse: pix_sof arrived mid-frame.
- frame_count  out  16  completed frames, saturating at 16'hFFFF.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, pix_cnt=0, all pixels entries=0.
  - frame_valid=0, resync_err=0, frame_count=0.
  - pix_ready=1 (combinational from state).
- Handshake: a pixel is accepted on a rising clk edge where pix_valid && pix_ready. pix_in is never sampled otherwise.
- Quantization:
  - p' = INVERT ? ~pix_in : pix_in.
  - stored value = {1'b0, p'[7:1]}, range 0..127 (Q0.7 non-negative).
- State IDLE, pix_ready=1:
  - Accept with pix_sof=1: store at index 0, pix_cnt=1, go to LOAD.
  - Accept with pix_sof=0: pixel discarded, stay IDLE.
- State LOAD, pix_ready=1:
  - Accept with pix_sof=0: store at pixels[pix_cnt], pix_cnt++.
  - Accept with pix_sof=1: resync. Store at index 0, pix_cnt=1, resync_err pulses 1 on the next cycle, stay LOAD. Stale entries are overwritten as the frame refills.
  - Accept at pix_cnt==PIXELS_NUMBER-1 with pix_sof=0: store, pix_cnt=0, go to READY. frame_valid=1 and frame_count++ (saturating) take effect the cycle after acceptance, i.e. one cycle of latency from the last pixel.
- State READY:
  - pix_ready=0, frame_valid=1, pixels held constant.
  - frame_ack=1: go to IDLE next edge. frame_valid=0 and pix_ready=1 on the following cycle. No pixel is accepted in the ack cycle.
  - frame_ack outside READY is ignored.
- Other rules:
  - pix_sof with pix_valid=0 is ignored.
  - pixels is not cleared when a frame is consumed; the contents are only meaningful while frame_valid=1.
  - Reset asserted mid-LOAD or mid-READY aborts the frame and returns everything to reset values; a partial frame is never presented.

Decomposition:
- Shared package mlp_pkg:
  - PIXELS_NUMBER=784, RESOLUTION=8, HL_NEURONS=30, OL_NEURONS=10.
  - typedef pixel_t (logic signed [7:0]).
  - typedef loader_state_t enum {IDLE, LOAD, READY}.
- One combinational sub-module pixel_quantizer (INVERT parameter, 8-bit in, signed 8-bit out), reused later by any camera/UART front end.

Test Plan:
- Reset, then a frame with pix_sof on pixel 0 and pix_in=index%256 -> frame_valid rises exactly 1 cycle after the 784th accept. pixels[0]=0, pixels[255]=127, pixels[783]=7 (783%256=15, 15>>1). frame_count=1.
- Frame with pix_valid toggling randomly (50% duty) -> identical pixels array to the back-to-back case. pix_ready stays 1 throughout LOAD.
- Second frame streamed while READY -> pix_ready=0 and the array is unchanged. Assert frame_ack -> frame_valid=0 one cycle later, new frame then loads. frame_count=2.
- pix_sof reasserted at pixel 400 with pix_in=200 -> resync_err pulses once, pixels[0]=100. frame_valid only after 784 further accepts.
- INVERT=1, pix_in=0 for all pixels -> every entry=127. Pixels sent in IDLE with pix_sof=0 are discarded, count unaffected.
- reset asserted mid-frame at pixel 500 -> frame_valid=0, all pixels=0, frame_count=0, pix_ready=1 immediately (asynchronous). A subsequent full frame loads correctly.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP inference datapath and its front ends.
package mlp_pkg;

    localparam int PIXELS_NUMBER = 784;
    localparam int RESOLUTION    = 8;
    localparam int HL_NEURONS    = 30;
    localparam int OL_NEURONS    = 10;

    typedef logic signed [RESOLUTION-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } loader_state_t;

endpackage

// File: rtl/pixel_quantizer.sv
// Maps an unsigned grayscale pixel onto the non-negative half of a signed
// Q0.7 range by dropping the LSB; optional inversion for white-background sources.
module pixel_quantizer #(
    parameter int RESOLUTION = mlp_pkg::RESOLUTION,
    parameter bit INVERT     = 1'b0
) (
    input  logic        [RESOLUTION-1:0] pix_in,
    output logic signed [RESOLUTION-1:0] pix_out
);

    logic [RESOLUTION-1:0] pix_oriented;

    // Optional complement, then shift right by one with a forced-zero sign bit.
    always_comb begin
        pix_oriented = INVERT ? ~pix_in : pix_in;
        pix_out      = {1'b0, pix_oriented[RESOLUTION-1:1]};
    end

endmodule

// File: rtl/pixel_frame_loader.sv
// Collects one raster-order frame of quantized pixels and holds it as a
// parallel array until the MLP core acknowledges it.
//
// state | meaning
// IDLE  | waiting for a pixel flagged with pix_sof; other pixels are dropped
// LOAD  | filling the buffer; pix_sof restarts the frame at index 0
// READY | complete frame presented, input stalled until frame_ack
module pixel_frame_loader #(
    parameter int PIXELS_NUMBER = mlp_pkg::PIXELS_NUMBER,
    parameter int RESOLUTION    = mlp_pkg::RESOLUTION,
    parameter bit INVERT        = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic        [RESOLUTION-1:0] pix_in,
    input  logic                         pix_valid,
    input  logic                         pix_sof,
    output logic                         pix_ready,
    output logic signed [RESOLUTION-1:0] pixels [PIXELS_NUMBER-1:0],
    output logic                         frame_valid,
    input  logic                         frame_ack,
    output logic                         resync_err,
    output logic        [15:0]           frame_count
);

    import mlp_pkg::*;

    localparam int              CNT_W    = $clog2(PIXELS_NUMBER);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_NUMBER - 1);

    loader_state_t               state_q, state_d;
    logic        [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                        resync_err_q, resync_err_d;
    logic        [15:0]          frame_count_q, frame_count_d;
    logic signed [RESOLUTION-1:0] pixels_q [PIXELS_NUMBER-1:0];
    logic signed [RESOLUTION-1:0] pixels_d [PIXELS_NUMBER-1:0];

    logic                        accept;
    logic                        store_en;
    logic        [CNT_W-1:0]     store_idx;
    logic signed [RESOLUTION-1:0] pix_quant;

    pixel_quantizer #(
        .RESOLUTION (RESOLUTION),
        .INVERT     (INVERT)
    ) u_quant (
        .pix_in  (pix_in),
        .pix_out (pix_quant)
    );

    // Input is only stalled while a finished frame waits for its consumer.
    always_comb begin
        pix_ready = (state_q != READY);
        accept    = pix_valid && pix_ready;
    end

    // Next-state, pixel counter, write strobe, resync pulse and frame counter.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        resync_err_d  = 1'b0;
        frame_count_d = frame_count_q;
        store_en      = 1'b0;
        store_idx     = '0;
        case (state_q)
            IDLE: begin
                if (accept && pix_sof) begin
                    store_en  = 1'b1;
                    store_idx = '0;
                    pix_cnt_d = CNT_W'(1);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    store_en = 1'b1;
                    if (pix_sof) begin
                        // Restart at index 0; stale entries get overwritten on refill.
                        store_idx    = '0;
                        pix_cnt_d    = CNT_W'(1);
                        resync_err_d = 1'b1;
                    end else begin
                        store_idx = pix_cnt_q;
                        if (pix_cnt_q == LAST_IDX) begin
                            pix_cnt_d = '0;
                            state_d   = READY;
                            if (frame_count_q != 16'hFFFF) begin
                                frame_count_d = frame_count_q + 16'd1;
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            READY: begin
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame buffer: single write port addressed by the pixel counter.
    always_comb begin
        pixels_d = pixels_q;
        if (store_en) begin
            pixels_d[store_idx] = pix_quant;
        end
    end

    // State and datapath registers; reset aborts any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pix_cnt_q     <= '0;
            resync_err_q  <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < PIXELS_NUMBER; i++) begin
                pixels_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            resync_err_q  <= resync_err_d;
            frame_count_q <= frame_count_d;
            pixels_q      <= pixels_d;
        end
    end

    // Output drives.
    always_comb begin
        frame_valid = (state_q == READY);
        resync_err  = resync_err_q;
        frame_count = frame_count_q;
        pixels      = pixels_q;
    end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench: a normal instance and an INVERT instance share all stimulus.
module tb_pixel_frame_loader;

    localparam int PN = 784;

    logic              clk;
    logic              reset;
    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              pix_sof;
    logic              frame_ack;
    logic              pix_ready0, pix_ready1;
    logic              frame_valid0, frame_valid1;
    logic              resync_err0, resync_err1;
    logic [15:0]       frame_count0, frame_count1;
    logic signed [7:0] pixels0 [PN-1:0];
    logic signed [7:0] pixels1 [PN-1:0];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int raw_m [PN];
    logic was_acc;

    pixel_frame_loader #(.PIXELS_NUMBER(PN), .RESOLUTION(8), .INVERT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready0), .pixels(pixels0),
        .frame_valid(frame_valid0), .frame_ack(frame_ack),
        .resync_err(resync_err0), .frame_count(frame_count0)
    );

    pixel_frame_loader #(.PIXELS_NUMBER(PN), .RESOLUTION(8), .INVERT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready1), .pixels(pixels1),
        .frame_valid(frame_valid1), .frame_ack(frame_ack),
        .resync_err(resync_err1), .frame_count(frame_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input beat, then advance past the next rising edge.
    task automatic cyc(input logic [7:0] p, input logic sof, input logic v);
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = v;
        was_acc   = v && pix_ready0;
        @(posedge clk);
        #1;
    endtask

    // Compare both buffers against the raw-pixel model.
    task automatic chk_frame(input string tag);
        int bad0, bad1, e0, e1;
        bad0 = 0;
        bad1 = 0;
        for (int i = 0; i < PN; i++) begin
            e0 = raw_m[i] >> 1;
            e1 = (255 - raw_m[i]) >> 1;
            if (int'(pixels0[i]) != e0) bad0++;
            if (int'(pixels1[i]) != e1) bad1++;
        end
        chk({tag, "_norm_bad"}, bad0, 0);
        chk({tag, "_inv_bad"}, bad1, 0);
    endtask

    task automatic chk_zero(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < PN; i++) begin
            if (pixels0[i] !== 8'sd0) bad++;
            if (pixels1[i] !== 8'sd0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        frame_ack = 1'b0;
    endtask

    initial begin
        int acc_n, stall_n, budget, pulses;
        reset     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        frame_ack = 1'b0;
        was_acc   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", pix_ready0, 1);
        chk("rst_fvalid", frame_valid0, 0);
        chk("rst_resync", resync_err0, 0);
        chk("rst_fcount", frame_count0, 0);
        chk_zero("rst_pixels");
        reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);

        // Frame A: back-to-back, pix_in = index % 256
        for (int i = 0; i < PN; i++) begin
            raw_m[i] = i % 256;
            cyc(8'(i % 256), i == 0, 1'b1);
            if (i == PN - 2) chk("a_fvalid_before_last", frame_valid0, 0);
        end
        pix_valid = 1'b0;
        chk("a_fvalid_after_last", frame_valid0, 1);
        chk("a_fcount", frame_count0, 1);
        chk("a_pix0", 32'(pixels0[0]), 0);
        chk("a_pix255", 32'(pixels0[255]), 127);
        chk("a_pix783", 32'(pixels0[783]), 7);
        chk("a_inv_pix0", 32'(pixels1[0]), 127);
        chk_frame("a");

        // Stream while READY: nothing accepted, array untouched
        acc_n = 0;
        stall_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (pix_ready0 !== 1'b0) stall_n++;
            cyc(8'hAA, 1'b1, 1'b1);
            if (was_acc) acc_n++;
        end
        pix_valid = 1'b0;
        chk("ready_not_ready", stall_n, 0);
        chk("ready_accepts", acc_n, 0);
        chk("ready_fcount", frame_count0, 1);
        chk_frame("ready_hold");
        ack_frame();
        chk("ack_fvalid", frame_valid0, 0);
        chk("ack_ready", pix_ready0, 1);

        // Frame B: pix_valid toggling randomly
        acc_n = 0;
        stall_n = 0;
        budget = 0;
        while (acc_n < PN && budget < 10000) begin
            if ($urandom_range(0, 1) == 1) begin
                if (acc_n > 0 && pix_ready0 !== 1'b1) stall_n++;
                cyc(8'(acc_n % 256), acc_n == 0, 1'b1);
                if (was_acc) acc_n++;
            end else begin
                cyc(8'hFF, 1'b1, 1'b0);
            end
            budget++;
        end
        pix_valid = 1'b0;
        chk("b_accepts", acc_n, PN);
        chk("b_ready_in_load", stall_n, 0);
        chk("b_fvalid", frame_valid0, 1);
        chk("b_fcount", frame_count0, 2);
        chk_frame("b");
        ack_frame();

        // Resync at pixel 400 with pix_in = 200
        for (int i = 0; i < 400; i++) cyc(8'(i % 256), i == 0, 1'b1);
        cyc(8'd200, 1'b1, 1'b1);
        chk("rs_pulse", resync_err0, 1);
        chk("rs_pix0", 32'(pixels0[0]), 100);
        raw_m[0] = 200;
        pulses = 0;
        for (int k = 1; k < PN; k++) begin
            raw_m[k] = (k + 7) % 256;
            cyc(8'((k + 7) % 256), 1'b0, 1'b1);
            if (k == 1) chk("rs_pulse_gone", resync_err0, 0);
            if (resync_err0 !== 1'b0) pulses++;
            if (k == PN - 2) chk("rs_fvalid_early", frame_valid0, 0);
        end
        pix_valid = 1'b0;
        chk("rs_extra_pulses", pulses, 0);
        chk("rs_fvalid", frame_valid0, 1);
        chk("rs_fcount", frame_count0, 3);
        chk_frame("rs");
        ack_frame();

        // IDLE pixels without pix_sof are discarded
        for (int i = 0; i < 5; i++) cyc(8'h55, 1'b0, 1'b1);
        pix_valid = 1'b0;
        chk("idle_fcount", frame_count0, 3);
        chk("idle_ready", pix_ready0, 1);
        chk("idle_pix0", 32'(pixels0[0]), 100);
        cyc(8'h00, 1'b0, 1'b0);
        chk("idle_fvalid", frame_valid0, 0);

        // All-zero frame: inverted instance must read 127 everywhere
        for (int i = 0; i < PN; i++) begin
            raw_m[i] = 0;
            cyc(8'h00, i == 0, 1'b1);
        end
        pix_valid = 1'b0;
        chk("inv_fvalid", frame_valid1, 1);
        chk("inv_fcount", frame_count1, 4);
        chk_frame("inv");
        ack_frame();

        // Reset mid-frame at pixel 500 is asynchronous
        for (int i = 0; i < 500; i++) cyc(8'(i % 256), i == 0, 1'b1);
        pix_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("mrst_fvalid", frame_valid0, 0);
        chk("mrst_ready", pix_ready0, 1);
        chk("mrst_fcount", frame_count0, 0);
        chk_zero("mrst_pixels");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);

        // Full frame after reset
        for (int i = 0; i < PN; i++) begin
            raw_m[i] = (i * 5) % 256;
            cyc(8'((i * 5) % 256), i == 0, 1'b1);
        end
        pix_valid = 1'b0;
        chk("post_fvalid", frame_valid0, 1);
        chk("post_fcount", frame_count0, 1);
        chk_frame("post");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
